// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the 16-bit word memory port.
// Each grant owns one whole access: strobes are replayed to memory, completed by ack or timed out with berr.
module mem_arbiter #(
  parameter int AW      = 18,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [15:0]   m0_wdata,
  input  logic          m0_uds,
  input  logic          m0_lds,
  input  logic          m0_rw,
  output logic [15:0]   m0_rdata,
  output logic          m0_ack,
  output logic          m0_berr,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [15:0]   m1_wdata,
  input  logic          m1_uds,
  input  logic          m1_lds,
  input  logic          m1_rw,
  output logic [15:0]   m1_rdata,
  output logic          m1_ack,
  output logic          m1_berr,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_data_write,
  input  logic [15:0]   mem_data_read,
  output logic          mem_uds,
  output logic          mem_lds,
  output logic          mem_rw,
  input  logic          mem_ack,
  output logic [1:0]    grant
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [TW-1:0] r_timer;
  logic          r_last;
  logic [15:0]   r_m0_rdata, r_m1_rdata;
  logic          r_m0_ack, r_m1_ack, r_m0_berr, r_m1_berr;
  logic [AW-1:0] r_mem_addr;
  logic [15:0]   r_mem_wdata;
  logic          r_mem_uds, r_mem_lds, r_mem_rw;
  logic [1:0]    r_grant;

  logic          w_m0_ok, w_m1_ok, w_sel_m1, w_sel_valid;
  logic [AW-1:0] w_sel_addr;
  logic [15:0]   w_sel_wdata;
  logic          w_sel_uds, w_sel_lds, w_sel_rw;
  logic          w_start, w_null, w_done, w_timeout;

  // A master whose ack/berr is on the wire this cycle still holds the old req; mask it
  assign w_m0_ok     = m0_req & ~r_m0_ack & ~r_m0_berr;
  assign w_m1_ok     = m1_req & ~r_m1_ack & ~r_m1_berr;
  assign w_sel_m1    = w_m1_ok & (~w_m0_ok | ~r_last);
  assign w_sel_valid = w_m0_ok | w_m1_ok;
  assign w_sel_addr  = w_sel_m1 ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_sel_m1 ? m1_wdata : m0_wdata;
  assign w_sel_uds   = w_sel_m1 ? m1_uds   : m0_uds;
  assign w_sel_lds   = w_sel_m1 ? m1_lds   : m0_lds;
  assign w_sel_rw    = w_sel_m1 ? m1_rw    : m0_rw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_null       = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sel_valid) begin
          if (w_sel_uds | w_sel_lds) begin
            w_start      = 1'b1;
            w_next_state = S_ACCESS;
          end else begin
            w_null = 1'b1;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          w_done       = 1'b1;
          w_next_state = S_IDLE;
        end else if (r_timer == TMAX) begin
          w_timeout    = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_ACCESS;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer     <= '0;
      r_last      <= 1'b1;
      r_m0_rdata  <= 16'h0000;
      r_m1_rdata  <= 16'h0000;
      r_m0_ack    <= 1'b0;
      r_m1_ack    <= 1'b0;
      r_m0_berr   <= 1'b0;
      r_m1_berr   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 16'h0000;
      r_mem_uds   <= 1'b0;
      r_mem_lds   <= 1'b0;
      r_mem_rw    <= 1'b1;
      r_grant     <= 2'b00;
    end else begin
      r_m0_ack  <= 1'b0;
      r_m1_ack  <= 1'b0;
      r_m0_berr <= 1'b0;
      r_m1_berr <= 1'b0;
      if (w_start) begin
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
        r_mem_uds   <= w_sel_uds;
        r_mem_lds   <= w_sel_lds;
        r_mem_rw    <= w_sel_rw;
        r_grant     <= w_sel_m1 ? 2'b10 : 2'b01;
        r_last      <= w_sel_m1;
        r_timer     <= '0;
      end else if (w_null) begin
        r_last <= w_sel_m1;
        if (w_sel_m1) begin
          r_m1_ack <= 1'b1;
        end else begin
          r_m0_ack <= 1'b1;
        end
      end else if (w_done) begin
        r_mem_uds <= 1'b0;
        r_mem_lds <= 1'b0;
        r_mem_rw  <= 1'b1;
        r_grant   <= 2'b00;
        if (r_grant[1]) begin
          r_m1_ack <= 1'b1;
          if (r_mem_rw) begin
            r_m1_rdata <= mem_data_read;
          end else begin
            r_m1_rdata <= r_m1_rdata;
          end
        end else begin
          r_m0_ack <= 1'b1;
          if (r_mem_rw) begin
            r_m0_rdata <= mem_data_read;
          end else begin
            r_m0_rdata <= r_m0_rdata;
          end
        end
      end else if (w_timeout) begin
        r_mem_uds <= 1'b0;
        r_mem_lds <= 1'b0;
        r_mem_rw  <= 1'b1;
        r_grant   <= 2'b00;
        if (r_grant[1]) begin
          r_m1_berr <= 1'b1;
        end else begin
          r_m0_berr <= 1'b1;
        end
      end else if (r_state == S_ACCESS) begin
        r_timer <= r_timer + TW'(1);
      end else begin
        r_timer <= r_timer;
      end
    end
  end

  assign m0_rdata       = r_m0_rdata;
  assign m1_rdata       = r_m1_rdata;
  assign m0_ack         = r_m0_ack;
  assign m1_ack         = r_m1_ack;
  assign m0_berr        = r_m0_berr;
  assign m1_berr        = r_m1_berr;
  assign mem_addr       = r_mem_addr;
  assign mem_data_write = r_mem_wdata;
  assign mem_uds        = r_mem_uds;
  assign mem_lds        = r_mem_lds;
  assign mem_rw         = r_mem_rw;
  assign grant          = r_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural word memory with registered ack, per-master
// scoreboard queues filled at request time and drained when ack/berr appears.
module tb_mem_arbiter;

  localparam int AW      = 18;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [AW-1:0] addr [2];
  logic [15:0]   wdata [2];
  logic [1:0]    uds = 2'b00, lds = 2'b00, rw = 2'b11;
  logic [15:0]   m0_rdata, m1_rdata;
  logic          m0_ack, m1_ack, m0_berr, m1_berr;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data_write;
  logic [15:0]   mem_data_read = 16'h0000;
  logic          mem_uds, mem_lds, mem_rw;
  logic          mem_ack = 1'b0;
  logic [1:0]    grant;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(req[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_uds(uds[0]), .m0_lds(lds[0]),
    .m0_rw(rw[0]), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_berr(m0_berr),
    .m1_req(req[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_uds(uds[1]), .m1_lds(lds[1]),
    .m1_rw(rw[1]), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_berr(m1_berr),
    .mem_addr(mem_addr), .mem_data_write(mem_data_write), .mem_data_read(mem_data_read),
    .mem_uds(mem_uds), .mem_lds(mem_lds), .mem_rw(mem_rw), .mem_ack(mem_ack), .grant(grant)
  );

  // Memory model: 1024 words, writes on the strobe rising edge, acks one cycle later
  logic [15:0] mem [0:1023];
  logic busy = 1'b0, prev_uds = 1'b0, prev_lds = 1'b0;
  int uds_rises = 0, lds_rises = 0, any_rises = 0;

  always @(posedge clk) begin
    if (mem_uds && !prev_uds) uds_rises <= uds_rises + 1;
    if (mem_lds && !prev_lds) lds_rises <= lds_rises + 1;
    if ((mem_uds || mem_lds) && !(prev_uds || prev_lds)) any_rises <= any_rises + 1;
    prev_uds <= mem_uds;
    prev_lds <= mem_lds;
    mem_ack  <= 1'b0;
    if (mem_uds || mem_lds) begin
      if (!busy && mem_addr < 18'd1024) begin
        if (!mem_rw && mem_uds) mem[mem_addr[9:0]][15:8] <= mem_data_write[15:8];
        if (!mem_rw && mem_lds) mem[mem_addr[9:0]][7:0]  <= mem_data_write[7:0];
        mem_data_read <= mem[mem_addr[9:0]];
        mem_ack       <= 1'b1;
        busy          <= 1'b1;
      end
    end else begin
      busy <= 1'b0;
    end
  end

  typedef struct packed { logic berr; logic is_read; logic [15:0] rdata; } exp_t;
  exp_t q0[$], q1[$];
  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  int grant_cyc [2];
  int grant_log[$];
  logic [1:0] prev_grant = 2'b00;
  bit mon_en = 1'b0;

  function automatic exp_t mk(input logic b, input logic r, input logic [15:0] d);
    exp_t e;
    e.berr = b; e.is_read = r; e.rdata = d;
    return e;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic service(input int m);
    exp_t e;
    logic a, b;
    logic [15:0] rd;
    a  = (m == 0) ? m0_ack : m1_ack;
    b  = (m == 0) ? m0_berr : m1_berr;
    rd = (m == 0) ? m0_rdata : m1_rdata;
    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
      check_eq($sformatf("m%0d_unexpected_resp", m), 32'({a, b}), 32'(0));
      return;
    end
    if (m == 0) e = q0.pop_front(); else e = q1.pop_front();
    check_eq($sformatf("m%0d_resp_kind", m), 32'({a, b}), e.berr ? 32'(2'b01) : 32'(2'b10));
    check_eq($sformatf("m%0d_strobes_low", m), 32'({mem_uds, mem_lds}), 32'(0));
    if (b) check_eq($sformatf("m%0d_berr_latency", m), 32'(cyc - grant_cyc[m]), 32'(TIMEOUT));
    if (a && e.is_read) check_eq($sformatf("m%0d_rdata", m), 32'(rd), 32'(e.rdata));
  endtask

  // Monitor: logs grants and scores every ack/berr pulse against the queues
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mon_en) begin
      for (int m = 0; m < 2; m++) begin
        if (grant[m] && !prev_grant[m]) begin
          grant_cyc[m] = cyc;
          grant_log.push_back(m);
        end
      end
      if (m0_ack || m0_berr) service(0);
      if (m1_ack || m1_berr) service(1);
    end
    prev_grant = grant;
  end

  task automatic access(input int m, input logic [AW-1:0] a, input logic [15:0] wd,
                        input logic u, input logic l, input logic r, input exp_t e, output int lat);
    bit done;
    if (m == 0) q0.push_back(e); else q1.push_back(e);
    @(negedge clk);
    addr[m] = a; wdata[m] = wd; uds[m] = u; lds[m] = l; rw[m] = r; req[m] = 1'b1;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (m == 0) done = m0_ack | m0_berr; else done = m1_ack | m1_berr;
    end
    req[m] = 1'b0;
    if (!done) check_eq($sformatf("m%0d_resp_timeout", m), 32'(done), 32'(1));
  endtask

  initial begin
    int la, lb, r0, u0, l0, n0;
    exp_t none;
    none = mk(1'b0, 1'b0, 16'h0000);
    addr[0] = '0; addr[1] = '0; wdata[0] = 16'h0000; wdata[1] = 16'h0000;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    repeat (3) @(negedge clk);
    check_eq("rst_grant", 32'(grant), 32'(0));
    check_eq("rst_strobes", 32'({mem_uds, mem_lds}), 32'(0));
    check_eq("rst_mem_rw", 32'(mem_rw), 32'(1));
    check_eq("rst_mem_addr", 32'(mem_addr), 32'(0));
    check_eq("rst_mem_wdata", 32'(mem_data_write), 32'(0));
    check_eq("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'(0));
    check_eq("rst_resp", 32'({m0_ack, m1_ack, m0_berr, m1_berr}), 32'(0));
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Write then read back through M0
    r0 = any_rises; u0 = uds_rises; l0 = lds_rises;
    access(0, 18'h00010, 16'hBEEF, 1'b1, 1'b1, 1'b0, none, la);
    check_eq("t1_one_rise", 32'(any_rises - r0), 32'(1));
    check_eq("t1_uds_rise", 32'(uds_rises - u0), 32'(1));
    check_eq("t1_lds_rise", 32'(lds_rises - l0), 32'(1));
    access(0, 18'h00010, 16'h0000, 1'b1, 1'b1, 1'b1, mk(1'b0, 1'b1, 16'hBEEF), la);

    // Simultaneous requests alternate; last winner was M0 so M1 leads
    grant_log.delete();
    for (int i = 0; i < 3; i++) begin
      fork
        access(0, 18'h00020 + 18'(i), 16'h1000 + 16'(i), 1'b1, 1'b1, 1'b0, none, la);
        access(1, 18'h00010, 16'h0000, 1'b1, 1'b1, 1'b1, mk(1'b0, 1'b1, 16'hBEEF), lb);
      join
    end
    check_eq("t2_grant_count", 32'(grant_log.size()), 32'(6));
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check_eq($sformatf("t2_grant_%0d", i), 32'(grant_log[i]), 32'((i % 2 == 0) ? 1 : 0));

    // Byte-lane write on lds only
    u0 = uds_rises; l0 = lds_rises;
    access(1, 18'h00010, 16'h0012, 1'b0, 1'b1, 1'b0, none, lb);
    check_eq("t3_uds_quiet", 32'(uds_rises - u0), 32'(0));
    check_eq("t3_lds_rise", 32'(lds_rises - l0), 32'(1));
    access(1, 18'h00010, 16'h0000, 1'b1, 1'b1, 1'b1, mk(1'b0, 1'b1, 16'hBE12), lb);

    // No strobes: immediate ack, no memory cycle, rdata unchanged
    r0 = any_rises; n0 = grant_log.size();
    access(0, 18'h00040, 16'h0000, 1'b0, 1'b0, 1'b1, mk(1'b0, 1'b1, 16'hBEEF), la);
    check_eq("t5_ack_latency", 32'(la), 32'(1));
    repeat (2) @(negedge clk);
    check_eq("t5_no_rise", 32'(any_rises - r0), 32'(0));
    check_eq("t5_no_grant", 32'(grant_log.size()), 32'(n0));

    // Unmapped address times out, then M1 proceeds
    access(0, 18'h3FFFF, 16'h0000, 1'b1, 1'b1, 1'b1, mk(1'b1, 1'b0, 16'h0000), la);
    check_eq("t4_rdata_kept", 32'(m0_rdata), 32'(16'hBEEF));
    access(1, 18'h00010, 16'h0000, 1'b1, 1'b1, 1'b1, mk(1'b0, 1'b1, 16'hBE12), lb);

    // Reset during ACCESS
    @(negedge clk);
    addr[0] = 18'h00030; wdata[0] = 16'h5555; uds[0] = 1'b1; lds[0] = 1'b1; rw[0] = 1'b0; req[0] = 1'b1;
    la = 0;
    while (grant[0] !== 1'b1 && la < 10) begin
      @(negedge clk);
      la++;
    end
    check_eq("t6_granted", 32'(grant), 32'(2'b01));
    reset_n = 1'b0;
    #1;
    check_eq("t6_strobes_drop", 32'({mem_uds, mem_lds}), 32'(0));
    check_eq("t6_grant_clear", 32'(grant), 32'(0));
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    grant_log.delete();
    fork
      access(0, 18'h00031, 16'h0001, 1'b1, 1'b1, 1'b0, none, la);
      access(1, 18'h00032, 16'h0002, 1'b1, 1'b1, 1'b0, none, lb);
    join
    check_eq("t6_tie_count", 32'(grant_log.size()), 32'(2));
    if (grant_log.size() > 0) check_eq("t6_first_tie_m0", 32'(grant_log[0]), 32'(0));
    repeat (3) @(negedge clk);
    check_eq("end_queues_empty", 32'(q0.size() + q1.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
